ks0108_panel_model: RTL

//  Responder side of our KS0108-style 128x64 graphic LCD bus: a synthesizable panel/controller model.

---
 rtl/ks0108_panel_model.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ks0108_panel_model.sv
// ---------------------------------------------------------------------------
// ks0108_panel_model
// Responder-side model of a KS0108-style 128x64 graphic LCD. It decodes bus
// cycles from an LCD driver, keeps two 64-column x 8-page display RAMs
// (CS1 = left half, CS2 = right half), answers status/data reads and offers a
// registered pixel probe for scoreboards.
//
// Optional feature macro: KS0108_DUMMY_READ_EN
//   defined   : data reads are pipelined through an output latch (real-chip
//               dummy-read behaviour)
//   undefined : data reads return RAM[page][Y] directly
//
// Ports
//   i_clk, i_reset      system clock, asynchronous active-high reset
//   i_lcd_enable        bus strobe, access commits on its falling edge
//   i_lcd_rstn          panel reset from the driver, active-low
//   i_lcd_cs1/cs2       half selects (left/right)
//   i_lcd_di, i_lcd_rw  0/1 = instruction/data, 0/1 = write/read
//   i_lcd_data          write data / instruction byte
//   o_lcd_dout          read data, valid while o_lcd_doe is high
//   i_pix_x, i_pix_y    pixel probe column (bit6 = right half) and row
//   o_pix               probed pixel, one cycle latency
//   o_disp_on           {right, left} display-on flags
//   o_err               sticky: a write or data read arrived while busy
//   o_wr_count          accepted data writes, saturating
// ---------------------------------------------------------------------------
module ks0108_panel_model #(
    parameter int unsigned BUSY_CYCLES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_enable,
    input  logic        i_lcd_rstn,
    input  logic        i_lcd_cs1,
    input  logic        i_lcd_cs2,
    input  logic        i_lcd_di,
    input  logic        i_lcd_rw,
    input  logic [7:0]  i_lcd_data,
    output logic [7:0]  o_lcd_dout,
    output logic        o_lcd_doe,
    input  logic [6:0]  i_pix_x,
    input  logic [5:0]  i_pix_y,
    output logic        o_pix,
    output logic [1:0]  o_disp_on,
    output logic        o_err,
    output logic [15:0] o_wr_count
);

    localparam int unsigned BW     = 14;
    localparam int unsigned B_EN   = 13;
    localparam int unsigned B_RSTN = 12;
    localparam int unsigned B_CS1  = 11;
    localparam int unsigned B_CS2  = 10;
    localparam int unsigned B_DI   = 9;
    localparam int unsigned B_RW   = 8;
    localparam int unsigned CW     = $clog2(BUSY_CYCLES + 1);

    // Enable resets high so a strobe already high at reset release is not
    // mistaken for a fresh rising edge.
    localparam logic [BW-1:0] SYNC_RST = BW'((1 << B_EN) | (1 << B_RSTN));

    logic [BW-1:0] w_bus_in;
    logic [BW-1:0] w_bus_s;
    logic [BW-1:0] r_sync [SYNC_STAGES];
    logic [BW-1:0] r_hold;
    logic          r_armed;
    logic          r_pend;
    logic          r_drop;
    logic          w_cap;
    logic          w_rise;
    logic          w_fall;

    logic [1:0]         r_on;
    logic [1:0][5:0]    r_start;
    logic [1:0][2:0]    r_page;
    logic [1:0][5:0]    r_y;
    logic [1:0][CW-1:0] r_busy;
    logic [7:0]         r_ram [2][512];
    logic               r_err;
    logic [15:0]        r_wr_count;
    logic [7:0]         r_dout;
    logic               r_doe;
    logic               r_pix;

    logic       w_ok;
    logic       w_status;
    logic       w_instr;
    logic       w_dwr;
    logic       w_drd;
    logic       w_ins_on;
    logic       w_ins_start;
    logic       w_ins_page;
    logic       w_ins_y;
    logic       w_ins_valid;
    logic [7:0] w_hd;
    logic [1:0] w_act;
    logic [1:0] w_acc;
    logic       w_err_set;

    logic       w_rh;
    logic       w_rd_req;
    logic [7:0] w_stat;
    logic [7:0] w_rdat;

    logic       w_ph;
    logic [5:0] w_line;
    logic [7:0] w_pbyte;

    assign w_bus_in = {i_lcd_enable, i_lcd_rstn, i_lcd_cs1, i_lcd_cs2,
                       i_lcd_di, i_lcd_rw, i_lcd_data};
    assign w_bus_s  = r_sync[SYNC_STAGES-1];

    // Input synchronizer chain for strobe and bus lines.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
        end else begin
            r_sync[0] <= w_bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Strobe edge detection; r_hold[B_EN] doubles as the previous strobe level.
    assign w_cap  = r_armed & w_bus_s[B_EN];
    assign w_rise = w_cap & ~r_hold[B_EN];
    assign w_fall = ~w_bus_s[B_EN] & r_hold[B_EN];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_armed <= 1'b0;
            r_hold  <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= w_fall;
            if (!w_bus_s[B_EN]) r_armed <= 1'b1;
            if (w_cap)       r_hold       <= w_bus_s;
            else if (w_fall) r_hold[B_EN] <= 1'b0;
        end
    end

    // Commit decode from the held bus cycle.
    assign w_hd        = r_hold[7:0];
    assign w_ok        = r_pend & w_bus_s[B_RSTN] & r_hold[B_RSTN];
    assign w_status    = ~r_hold[B_DI] &  r_hold[B_RW];
    assign w_instr     = ~r_hold[B_DI] & ~r_hold[B_RW];
    assign w_dwr       =  r_hold[B_DI] & ~r_hold[B_RW];
    assign w_drd       =  r_hold[B_DI] &  r_hold[B_RW];
    assign w_ins_on    = (w_hd[7:1] == 7'b0011111);
    assign w_ins_start = (w_hd[7:6] == 2'b11);
    assign w_ins_page  = (w_hd[7:3] == 5'b10111);
    assign w_ins_y     = (w_hd[7:6] == 2'b01);
    assign w_ins_valid = w_ins_on | w_ins_start | w_ins_page | w_ins_y;

    // Halves addressed by the committing access and whether each is free.
    always_comb begin
        w_act     = 2'b00;
        w_acc     = 2'b00;
        w_err_set = 1'b0;
        if (w_ok && !w_status) begin
            if ((w_instr && w_ins_valid) || w_dwr)
                w_act = {r_hold[B_CS2], r_hold[B_CS1]};
            else if (w_drd)
                w_act = r_hold[B_CS1] ? 2'b01 : {r_hold[B_CS2], 1'b0};
        end
        for (int h = 0; h < 2; h++) begin
            w_acc[h] = w_act[h] & (r_busy[h] == '0);
            if (w_act[h] && (r_busy[h] != '0)) w_err_set = 1'b1;
        end
    end

    // Per-half control state, error flag and write counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_on       <= '0;
            r_start    <= '0;
            r_page     <= '0;
            r_y        <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else if (!w_bus_s[B_RSTN]) begin
            r_on    <= '0;
            r_start <= '0;
            r_page  <= '0;
            r_y     <= '0;
            r_busy  <= '0;
        end else begin
            for (int h = 0; h < 2; h++) begin
                if (w_acc[h])             r_busy[h] <= CW'(BUSY_CYCLES);
                else if (r_busy[h] != '0) r_busy[h] <= r_busy[h] - CW'(1);
                if (w_acc[h]) begin
                    if (w_instr) begin
                        if (w_ins_on)         r_on[h]    <= w_hd[0];
                        else if (w_ins_start) r_start[h] <= w_hd[5:0];
                        else if (w_ins_page)  r_page[h]  <= w_hd[2:0];
                        else                  r_y[h]     <= w_hd[5:0];
                    end else begin
                        r_y[h] <= r_y[h] + 6'd1;
                    end
                end
            end
            if (w_err_set) r_err <= 1'b1;
            if (w_dwr && (w_acc != 2'b00) && (r_wr_count != 16'hFFFF))
                r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Display RAMs, deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int h = 0; h < 2; h++) begin
            if (w_acc[h] && w_dwr) r_ram[h][{r_page[h], r_y[h]}] <= w_hd;
        end
    end

    // Read response: data is presented from the synchronized rising strobe.
    assign w_rh     = ~w_bus_s[B_CS1];
    assign w_rd_req = w_rise & w_bus_s[B_RW] & (w_bus_s[B_CS1] | w_bus_s[B_CS2])
                    & (~w_bus_s[B_DI] | w_bus_s[B_RSTN]);
    assign w_stat   = {(r_busy[w_rh] != '0), 1'b0, ~r_on[w_rh], ~w_bus_s[B_RSTN], 4'b0000};
    assign w_rdat   = r_ram[w_rh][{r_page[w_rh], r_y[w_rh]}];

`ifdef KS0108_DUMMY_READ_EN
    logic [1:0][7:0] r_latch;

    // Output latch reloaded at commit from the pre-increment address.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_latch <= '0;
        end else begin
            for (int h = 0; h < 2; h++) begin
                if (w_acc[h] && w_drd) r_latch[h] <= r_ram[h][{r_page[h], r_y[h]}];
            end
        end
    end

    logic [7:0] w_rd_src;
    assign w_rd_src = r_latch[w_rh];
`else
    logic [7:0] w_rd_src;
    assign w_rd_src = w_rdat;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dout <= '0;
            r_doe  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= r_pend;
            if (r_drop)        r_doe <= 1'b0;
            else if (w_rd_req) r_doe <= 1'b1;
            if (w_rd_req) r_dout <= w_bus_s[B_DI] ? w_rd_src : w_stat;
        end
    end

    // Pixel probe: displayed row is offset by the half's start line.
    assign w_ph    = i_pix_x[6];
    assign w_line  = i_pix_y + r_start[w_ph];
    assign w_pbyte = r_ram[w_ph][{w_line[5:3], i_pix_x[5:0]}];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_pix <= 1'b0;
        else         r_pix <= r_on[w_ph] & w_pbyte[w_line[2:0]];
    end

    assign o_lcd_dout = r_dout;
    assign o_lcd_doe  = r_doe;
    assign o_pix      = r_pix;
    assign o_disp_on  = r_on;
    assign o_err      = r_err;
    assign o_wr_count = r_wr_count;

endmodule
